// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order holding buffer between dispatcher and ALU
// Optional feature macro: RS_CDB_FORWARD_EN (CDB results count toward readiness in the broadcast cycle)
// Ports:
//   Sys_clk, Sys_rst (async active-low), Sys_rdy (global enable), RoBRS_pre_judge (0 = flush)
//   DPRS_*      : dispatch input (en, pc, opcode, Qj/Qk tags, Vj/Vk values, imm, RoB tag)
//   RSDP_full   : back-pressure to dispatcher
//   CDBRS_RS_*  : ALU result broadcast; CDBRS_LSB_* : load result broadcast
//   RSALU_*     : registered issue port to the ALU
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int RS_IDX_WIDTH = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH = 8,
  parameter int EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'b100000000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    RoBRS_pre_judge,
  input  logic                    DPRS_en,
  input  logic [ADDR_WIDTH-1:0]   DPRS_pc,
  input  logic [6:0]              DPRS_opcode,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
  input  logic [31:0]             DPRS_Vj,
  input  logic [31:0]             DPRS_Vk,
  input  logic [31:0]             DPRS_imm,
  input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
  output logic                    RSDP_full,
  input  logic                    CDBRS_RS_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index,
  input  logic [31:0]             CDBRS_RS_value,
  input  logic                    CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
  input  logic [31:0]             CDBRS_LSB_value,
  output logic                    RSALU_en,
  output logic [ADDR_WIDTH-1:0]   RSALU_pc,
  output logic [6:0]              RSALU_opcode,
  output logic [31:0]             RSALU_Vj,
  output logic [31:0]             RSALU_Vk,
  output logic [31:0]             RSALU_imm,
  output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);

  localparam logic [RS_IDX_WIDTH:0] CNT_ONE    = (RS_IDX_WIDTH+1)'(1);
  localparam logic [RS_IDX_WIDTH:0] FULL_LEVEL = (RS_IDX_WIDTH+1)'(RS_SIZE - 1);

  logic [RS_SIZE-1:0]      busy_q;
  logic [EX_RoB_WIDTH-1:0] qj_q [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qk_q [RS_SIZE];
  logic [31:0]             vj_q [RS_SIZE];
  logic [31:0]             vk_q [RS_SIZE];
  logic [31:0]             imm_q [RS_SIZE];
  logic [ADDR_WIDTH-1:0]   pc_q [RS_SIZE];
  logic [6:0]              op_q [RS_SIZE];
  logic [RoB_WIDTH-1:0]    rob_q [RS_SIZE];
  logic [RS_IDX_WIDTH:0]   busy_cnt;

  // Broadcast tags widened to the stored tag format; the extra MSB is 0, so
  // they can never match NON_DEP.
  logic [EX_RoB_WIDTH-1:0] rs_tag, lsb_tag;
  assign rs_tag  = {1'b0, CDBRS_RS_RoB_index};
  assign lsb_tag = {1'b0, CDBRS_LSB_RoB_index};

  logic [RS_SIZE-1:0] j_rs_hit, j_lsb_hit, k_rs_hit, k_lsb_hit;
  logic [RS_SIZE-1:0] j_ok, k_ok, ready;

  always_comb begin
    j_rs_hit = '0; j_lsb_hit = '0; k_rs_hit = '0; k_lsb_hit = '0;
    j_ok = '0; k_ok = '0; ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      j_rs_hit[i]  = CDBRS_RS_en  && (qj_q[i] == rs_tag);
      j_lsb_hit[i] = CDBRS_LSB_en && (qj_q[i] == lsb_tag);
      k_rs_hit[i]  = CDBRS_RS_en  && (qk_q[i] == rs_tag);
      k_lsb_hit[i] = CDBRS_LSB_en && (qk_q[i] == lsb_tag);
`ifdef RS_CDB_FORWARD_EN
      j_ok[i] = (qj_q[i] == NON_DEP) || j_rs_hit[i] || j_lsb_hit[i];
      k_ok[i] = (qk_q[i] == NON_DEP) || k_rs_hit[i] || k_lsb_hit[i];
`else
      j_ok[i] = (qj_q[i] == NON_DEP);
      k_ok[i] = (qk_q[i] == NON_DEP);
`endif
      ready[i] = busy_q[i] && j_ok[i] && k_ok[i];
    end
  end

  // Lowest-index priority: scan downward so the last hit wins.
  logic [RS_IDX_WIDTH-1:0] free_idx, issue_idx;
  logic                    free_found, issue_found;

  always_comb begin
    free_idx = '0; free_found = 1'b0;
    issue_idx = '0; issue_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = RS_IDX_WIDTH'(i);
        free_found = 1'b1;
      end
      if (ready[i]) begin
        issue_idx = RS_IDX_WIDTH'(i);
        issue_found = 1'b1;
      end
    end
  end

  logic [31:0] iss_vj, iss_vk;

  always_comb begin
    iss_vj = vj_q[issue_idx];
    iss_vk = vk_q[issue_idx];
`ifdef RS_CDB_FORWARD_EN
    // A still-pending operand on the selected entry can only be here because a
    // bus is delivering it right now.
    if (qj_q[issue_idx] != NON_DEP) iss_vj = j_rs_hit[issue_idx] ? CDBRS_RS_value : CDBRS_LSB_value;
    if (qk_q[issue_idx] != NON_DEP) iss_vk = k_rs_hit[issue_idx] ? CDBRS_RS_value : CDBRS_LSB_value;
`endif
  end

  // Incoming dispatch snoops both buses so it never misses a same-cycle result.
  logic [EX_RoB_WIDTH-1:0] dp_qj, dp_qk;
  logic [31:0]             dp_vj, dp_vk;

  always_comb begin
    dp_qj = DPRS_Qj; dp_vj = DPRS_Vj;
    dp_qk = DPRS_Qk; dp_vk = DPRS_Vk;
    if (CDBRS_RS_en && DPRS_Qj == rs_tag) begin
      dp_qj = NON_DEP; dp_vj = CDBRS_RS_value;
    end else if (CDBRS_LSB_en && DPRS_Qj == lsb_tag) begin
      dp_qj = NON_DEP; dp_vj = CDBRS_LSB_value;
    end
    if (CDBRS_RS_en && DPRS_Qk == rs_tag) begin
      dp_qk = NON_DEP; dp_vk = CDBRS_RS_value;
    end else if (CDBRS_LSB_en && DPRS_Qk == lsb_tag) begin
      dp_qk = NON_DEP; dp_vk = CDBRS_LSB_value;
    end
  end

  logic alloc, do_issue;
  assign alloc    = Sys_rdy && DPRS_en && free_found;
  assign do_issue = Sys_rdy && issue_found;

  assign RSDP_full = (busy_cnt >= FULL_LEVEL);

  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      busy_q          <= '0;
      busy_cnt        <= '0;
      RSALU_en        <= 1'b0;
      RSALU_pc        <= '0;
      RSALU_opcode    <= '0;
      RSALU_Vj        <= '0;
      RSALU_Vk        <= '0;
      RSALU_imm       <= '0;
      RSALU_RoB_index <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        qj_q[i] <= NON_DEP;
        qk_q[i] <= NON_DEP;
      end
    end else if (!RoBRS_pre_judge) begin
      busy_q   <= '0;
      busy_cnt <= '0;
      RSALU_en <= 1'b0;
    end else if (Sys_rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && (j_rs_hit[i] || j_lsb_hit[i])) qj_q[i] <= NON_DEP;
        if (busy_q[i] && (k_rs_hit[i] || k_lsb_hit[i])) qk_q[i] <= NON_DEP;
      end
      if (do_issue) busy_q[issue_idx] <= 1'b0;
      if (alloc) begin
        busy_q[free_idx] <= 1'b1;
        qj_q[free_idx]   <= dp_qj;
        qk_q[free_idx]   <= dp_qk;
      end
      RSALU_en <= do_issue;
      if (do_issue) begin
        RSALU_pc        <= pc_q[issue_idx];
        RSALU_opcode    <= op_q[issue_idx];
        RSALU_Vj        <= iss_vj;
        RSALU_Vk        <= iss_vk;
        RSALU_imm       <= imm_q[issue_idx];
        RSALU_RoB_index <= rob_q[issue_idx];
      end
      case ({alloc, do_issue})
        2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
        2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through busy entries.
  always_ff @(posedge Sys_clk) begin
    if (RoBRS_pre_judge && Sys_rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && j_rs_hit[i])       vj_q[i] <= CDBRS_RS_value;
        else if (busy_q[i] && j_lsb_hit[i]) vj_q[i] <= CDBRS_LSB_value;
        if (busy_q[i] && k_rs_hit[i])       vk_q[i] <= CDBRS_RS_value;
        else if (busy_q[i] && k_lsb_hit[i]) vk_q[i] <= CDBRS_LSB_value;
      end
      if (alloc) begin
        pc_q[free_idx]  <= DPRS_pc;
        op_q[free_idx]  <= DPRS_opcode;
        imm_q[free_idx] <= DPRS_imm;
        rob_q[free_idx] <= DPRS_RoB_index;
        vj_q[free_idx]  <= dp_vj;
        vk_q[free_idx]  <= dp_vk;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;

  localparam logic [8:0] NON_DEP = 9'b100000000;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy, RoBRS_pre_judge;
  logic        DPRS_en;
  logic [31:0] DPRS_pc;
  logic [6:0]  DPRS_opcode;
  logic [8:0]  DPRS_Qj, DPRS_Qk;
  logic [31:0] DPRS_Vj, DPRS_Vk, DPRS_imm;
  logic [7:0]  DPRS_RoB_index;
  logic        RSDP_full;
  logic        CDBRS_RS_en, CDBRS_LSB_en;
  logic [7:0]  CDBRS_RS_RoB_index, CDBRS_LSB_RoB_index;
  logic [31:0] CDBRS_RS_value, CDBRS_LSB_value;
  logic        RSALU_en;
  logic [31:0] RSALU_pc;
  logic [6:0]  RSALU_opcode;
  logic [31:0] RSALU_Vj, RSALU_Vk, RSALU_imm;
  logic [7:0]  RSALU_RoB_index;

  always #5 Sys_clk = ~Sys_clk;

  reservation_station dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .RoBRS_pre_judge(RoBRS_pre_judge),
    .DPRS_en(DPRS_en), .DPRS_pc(DPRS_pc), .DPRS_opcode(DPRS_opcode),
    .DPRS_Qj(DPRS_Qj), .DPRS_Qk(DPRS_Qk), .DPRS_Vj(DPRS_Vj), .DPRS_Vk(DPRS_Vk),
    .DPRS_imm(DPRS_imm), .DPRS_RoB_index(DPRS_RoB_index), .RSDP_full(RSDP_full),
    .CDBRS_RS_en(CDBRS_RS_en), .CDBRS_RS_RoB_index(CDBRS_RS_RoB_index),
    .CDBRS_RS_value(CDBRS_RS_value),
    .CDBRS_LSB_en(CDBRS_LSB_en), .CDBRS_LSB_RoB_index(CDBRS_LSB_RoB_index),
    .CDBRS_LSB_value(CDBRS_LSB_value),
    .RSALU_en(RSALU_en), .RSALU_pc(RSALU_pc), .RSALU_opcode(RSALU_opcode),
    .RSALU_Vj(RSALU_Vj), .RSALU_Vk(RSALU_Vk), .RSALU_imm(RSALU_imm),
    .RSALU_RoB_index(RSALU_RoB_index)
  );

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [7:0]  rob;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic [6:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [31:0] imm, input logic [7:0] rob);
    exp_t e;
    e.pc = pc; e.op = op; e.vj = vj; e.vk = vk; e.imm = imm; e.rob = rob;
    exp_q.push_back(e);
  endtask

  task automatic dp(input logic [31:0] pc, input logic [6:0] op, input logic [8:0] qj,
                    input logic [8:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                    input logic [31:0] imm, input logic [7:0] rob);
    DPRS_en = 1'b1; DPRS_pc = pc; DPRS_opcode = op; DPRS_Qj = qj; DPRS_Qk = qk;
    DPRS_Vj = vj; DPRS_Vk = vk; DPRS_imm = imm; DPRS_RoB_index = rob;
    step();
    DPRS_en = 1'b0;
  endtask

  // Every issue strobe must match the oldest outstanding expectation.
  always @(negedge Sys_clk) begin
    if (Sys_rst && RSALU_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("iss_pc", RSALU_pc, e.pc);
        check("iss_opcode", RSALU_opcode, e.op);
        check("iss_vj", RSALU_Vj, e.vj);
        check("iss_vk", RSALU_Vk, e.vk);
        check("iss_imm", RSALU_imm, e.imm);
        check("iss_rob", RSALU_RoB_index, e.rob);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Sys_rst = 1'b1; Sys_rdy = 1'b1; RoBRS_pre_judge = 1'b1;
    DPRS_en = 1'b0; DPRS_pc = '0; DPRS_opcode = '0; DPRS_Qj = NON_DEP; DPRS_Qk = NON_DEP;
    DPRS_Vj = '0; DPRS_Vk = '0; DPRS_imm = '0; DPRS_RoB_index = '0;
    CDBRS_RS_en = 1'b0; CDBRS_RS_RoB_index = '0; CDBRS_RS_value = '0;
    CDBRS_LSB_en = 1'b0; CDBRS_LSB_RoB_index = '0; CDBRS_LSB_value = '0;
    #2 Sys_rst = 1'b0;
    #1;
    check("rst_en", RSALU_en, 0);
    check("rst_full", RSDP_full, 0);
    check("rst_pc", RSALU_pc, 0);
    step(); step();
    Sys_rst = 1'b1;
    step();

    // addi with both operands valid: two-cycle dispatch-to-issue latency
    expect_issue(32'h100, 7'd19, 32'd5, 32'd0, 32'd7, 8'd3);
    dp(32'h100, 7'd19, NON_DEP, NON_DEP, 32'd5, 32'd0, 32'd7, 8'd3);
    check("addi_en_e1", RSALU_en, 0);
    step();
    check("addi_en_e2", RSALU_en, 1);
    step();
    check("addi_en_e3", RSALU_en, 0);

    // add waiting on tag 4 from the ALU bus
    expect_issue(32'h200, 7'd28, 32'd40, 32'd2, 32'd0, 8'd5);
    dp(32'h200, 7'd28, 9'h004, NON_DEP, 32'd0, 32'd2, 32'd0, 8'd5);
    check("add_en_e1", RSALU_en, 0);
    step();
    check("add_en_e2", RSALU_en, 0);
    step();
    check("add_en_e3", RSALU_en, 0);
    CDBRS_RS_en = 1'b1; CDBRS_RS_RoB_index = 8'd4; CDBRS_RS_value = 32'd40;
    step();
    CDBRS_RS_en = 1'b0;
`ifdef RS_CDB_FORWARD_EN
    check("add_en_e4", RSALU_en, 1);
    step();
    check("add_en_e5", RSALU_en, 0);
`else
    check("add_en_e4", RSALU_en, 0);
    step();
    check("add_en_e5", RSALU_en, 1);
`endif
    step();

    // dispatch snoops the load bus in the same cycle
    expect_issue(32'h300, 7'd14, 32'd1, 32'hDEAD, 32'd0, 8'd6);
    CDBRS_LSB_en = 1'b1; CDBRS_LSB_RoB_index = 8'd10; CDBRS_LSB_value = 32'hDEAD;
    dp(32'h300, 7'd14, NON_DEP, 9'h00A, 32'd1, 32'd0, 32'd0, 8'd6);
    CDBRS_LSB_en = 1'b0;
    check("snoop_en_e1", RSALU_en, 0);
    step();
    check("snoop_en_e2", RSALU_en, 1);
    step();

    // asynchronous reset while three entries wait on tag 50
    for (int k = 0; k < 3; k++)
      dp(32'h400 + 32'(k * 4), 7'd20, 9'h032, NON_DEP, 32'd0, 32'd0, 32'd0, 8'(20 + k));
    #2 Sys_rst = 1'b0;
    #1;
    check("arst_en", RSALU_en, 0);
    check("arst_pc", RSALU_pc, 0);
    check("arst_opcode", RSALU_opcode, 0);
    check("arst_vj", RSALU_Vj, 0);
    check("arst_vk", RSALU_Vk, 0);
    check("arst_imm", RSALU_imm, 0);
    check("arst_rob", RSALU_RoB_index, 0);
    check("arst_full", RSDP_full, 0);
    step();
    Sys_rst = 1'b1;
    CDBRS_RS_en = 1'b1; CDBRS_RS_RoB_index = 8'd50; CDBRS_RS_value = 32'h55;
    step();
    CDBRS_RS_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("arst_no_issue", RSALU_en, 0);
      step();
    end

    // fill seven entries blocked on tag 1, then release them all
    for (int k = 0; k < 7; k++) begin
      expect_issue(32'h500 + 32'(k * 4), 7'd20, 32'h111, 32'(k), 32'd0, 8'(16 + k));
      dp(32'h500 + 32'(k * 4), 7'd20, 9'h001, NON_DEP, 32'd0, 32'(k), 32'd0, 8'(16 + k));
      if (k == 5) check("fill_full_at6", RSDP_full, 0);
    end
    check("fill_full_at7", RSDP_full, 1);
    CDBRS_RS_en = 1'b1; CDBRS_RS_RoB_index = 8'd1; CDBRS_RS_value = 32'h111;
    step();
    CDBRS_RS_en = 1'b0;
    n = 0;
    while (!RSALU_en && n < 10) begin
      step();
      n++;
    end
    check("fill_start", RSALU_en, 1);
`ifdef RS_CDB_FORWARD_EN
    check("fill_latency", 64'(n), 0);
`else
    check("fill_latency", 64'(n), 1);
`endif
    check("fill_full_drop", RSDP_full, 0);
    for (int k = 1; k < 7; k++) begin
      step();
      check("fill_seq_en", RSALU_en, 1);
    end
    step();
    check("fill_done", RSALU_en, 0);

    // flush beats a simultaneous dispatch and wake-up
    for (int k = 0; k < 4; k++)
      dp(32'h600 + 32'(k * 4), 7'd20, 9'h002, NON_DEP, 32'd0, 32'd0, 32'd0, 8'(30 + k));
    RoBRS_pre_judge = 1'b0;
    CDBRS_RS_en = 1'b1; CDBRS_RS_RoB_index = 8'd2; CDBRS_RS_value = 32'h22;
    dp(32'h700, 7'd19, NON_DEP, NON_DEP, 32'd1, 32'd1, 32'd1, 8'd40);
    RoBRS_pre_judge = 1'b1;
    CDBRS_RS_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("flush_no_issue", RSALU_en, 0);
      step();
    end
    CDBRS_RS_en = 1'b1; CDBRS_RS_RoB_index = 8'd2; CDBRS_RS_value = 32'h22;
    step();
    CDBRS_RS_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("flush_no_late_issue", RSALU_en, 0);
      step();
    end
    check("flush_full", RSDP_full, 0);

    // a zero count after flush means full appears exactly at seven entries
    for (int k = 0; k < 7; k++) begin
      dp(32'h800 + 32'(k * 4), 7'd20, 9'h003, NON_DEP, 32'd0, 32'd0, 32'd0, 8'(50 + k));
      if (k == 5) check("flushcnt_full_at6", RSDP_full, 0);
    end
    check("flushcnt_full_at7", RSDP_full, 1);
    RoBRS_pre_judge = 1'b0;
    step();
    RoBRS_pre_judge = 1'b1;
    check("final_full", RSDP_full, 0);
    step(); step();
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
